div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
Multi-cycle 32-bit integer divider for the execute stage. It is the inverse-operation counterpart of the pipelined multiplier and uses the same en / is_signed / is_flush / done handshake. It implements radix-2 restoring division on operand magnitudes, then applies a sign fix-up. A single invocation produces both quotient and remainder, serving DIV/MOD in signed and unsigned forms.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
is_flush  in  1  pipeline flush; aborts any operation in progress
en  in  1  start request; also the back-to-back request when sampled in S_DONE
is_signed  in  1  1 = two's-complement operands, 0 = unsigned
a  in  WIDTH  dividend
b  in  WIDTH  divisor
q  out  WIDTH  quotient, registered
r  out  WIDTH  remainder, registered
done  out  1  result valid; high for one cycle per completed operation
busy  out  1  high in S_ITER and S_FIX (combinational from state)

Behaviour:
- Reset (async, any time): state=S_IDLE, done=0, q=0, r=0, iteration counter=0. Internal datapath registers need not reset.
- States (one-hot): S_IDLE, S_ITER, S_FIX, S_DONE.
- Cycle numbering: cycle k is the period after the k-th rising edge. en high in cycle 0.
- Start: in S_IDLE or S_DONE with en=1, the next edge latches the following, then moves to S_ITER with cnt=0:
  - |a| and |b|; negation applies only when is_signed and the MSB is set.
  - neg_q = is_signed & (a[MSB]^b[MSB]).
  - neg_r = is_signed & a[MSB].
  - div0 = (b==0).
  - dividend a, for the div-by-zero result.
  - a, b and is_signed are ignored at all other times.
- S_ITER: each edge performs one restoring step and increments cnt.
  - partial remainder {rem, quo} shifts left by 1.
  - trial = rem - |b|; if no borrow, rem=trial and quo LSB=1; otherwise quo LSB=0.
  - After WIDTH steps (cnt=WIDTH-1 on that edge), state goes to S_FIX.
- S_FIX: the next edge registers outputs, sets done=1 and moves to S_DONE.
  - Normal: q = neg_q ? -quo : quo; r = neg_r ? -rem : rem.
  - div0: q = all ones, r = latched dividend; sign fix is bypassed.
- Latency: fixed. done=1 in cycle WIDTH+2 (cycle 34 for WIDTH=32) for every operand value, including div-by-zero.
- S_DONE:
  - done is high only while in S_DONE; q and r hold until the next completion.
  - en=1 starts a new operation at the next edge (done drops to 0); otherwise the block returns to S_IDLE.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0. This result comes naturally from the magnitude path; no special case is needed.
- Truncation toward zero: the remainder takes the dividend's sign.
- Flush:
  - is_flush=1 forces next=S_IDLE from any state, overriding en, and clears done at that edge.
  - q and r hold their previous values.
  - en in the same cycle as is_flush is ignored.
- en while busy is ignored; no queuing.
- Reset mid-operation behaves identically to flush, except that q and r are also cleared.

Decomposition:
- Shared exec package holds:
  - the divider state enum typedef, one-hot: S_IDLE=4'b1000, S_ITER=4'b0100, S_FIX=4'b0010, S_DONE=4'b0001.
  - the DIV_ITERS constant.
- One natural sub-module: div_step. It is a purely combinational single restoring step: inputs rem, quo, divisor; outputs next rem, next quo. It is instantiated once.

Test Plan:
- Unsigned 100/7 (a=0x64, b=0x7, is_signed=0), en pulsed in cycle 0 -> done=1 in cycle 34 only; q=14, r=2. Before that, busy=1 in cycles 1–33.
- Signed -7/2 (a=0xFFFFFFF9, b=2) -> q=0xFFFFFFFD (-3), r=0xFFFFFFFF (-1). Also check 7/-2 -> q=-3, r=1.
- Overflow and unsigned wide: signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; same operands unsigned -> q=0, r=0x80000000.
- Div-by-zero: a=0x12345678, b=0, signed and unsigned -> q=0xFFFFFFFF, r=0x12345678; done still arrives in cycle 34.
- Flush at cycle 10 of 1000/3 -> state S_IDLE at the next edge, no done pulse, q/r unchanged. A new 1000/3 issued afterwards -> q=333, r=1.
- Back-to-back: en held high with 50/5 then 9/4 -> done pulses in cycle 34 (q=10, r=0) and cycle 68 (q=2, r=1). done is low in between. Asserting rst_n low mid-op -> q=0, r=0, done=0 immediately.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared execute-stage definitions for the multi-cycle divider.
// Holds the one-hot state encoding and the iteration count.
package div_unit_pkg;

    localparam int DIV_ITERS = 32;

    typedef enum logic [3:0] {
        S_IDLE = 4'b1000,
        S_ITER = 4'b0100,
        S_FIX  = 4'b0010,
        S_DONE = 4'b0001
    } div_state_e;

endpackage

// File: rtl/div_unit_if.sv
// Request/result bundle between the execute stage (master) and the divider (slave).
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_ITERS
);
    logic             en;
    logic             is_signed;
    logic             is_flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             done;
    logic             busy;

    modport master (
        output en, is_signed, is_flush, a, b,
        input  q, r, done, busy
    );

    modport slave (
        input  en, is_signed, is_flush, a, b,
        output q, r, done, busy
    );

endinterface

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift {rem, quo} left, then subtract
// the divisor if it fits and record the outcome in the quotient LSB.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] shifted;
    logic           borrow;

    // Partial remainder is below the divisor, so one extra bit holds the shift.
    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign borrow  = shifted < {1'b0, divisor_i};
    assign rem_o   = borrow ? shifted[WIDTH-1:0] : shifted[WIDTH-1:0] - divisor_i;
    assign quo_o   = {quo_i[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned integer divider: restoring division on operand
// magnitudes, followed by a sign fix-up; fixed latency of WIDTH+2 cycles.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_ITERS
) (
    input logic       clk,
    input logic       rst_n,
    div_unit_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] q_q, r_q;

    logic [WIDTH-1:0] rem_q, quo_q, dvs_q, dvd_q;
    logic             neg_quo_q, neg_rem_q, div0_q;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic [WIDTH-1:0] mag_a, mag_b, q_fix, r_fix;
    logic             load, step_en, fix_en;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic             is_signed);
        return (is_signed && v[WIDTH-1]) ? -v : v;
    endfunction

    assign mag_a = magnitude(bus.a, bus.is_signed);
    assign mag_b = magnitude(bus.b, bus.is_signed);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step_en = 1'b0;
        fix_en  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.en) begin
                    state_d = S_ITER;
                    cnt_d   = '0;
                    load    = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ITER: begin
                step_en = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                fix_en  = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins over everything, including a same-cycle start request.
        if (bus.is_flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            load    = 1'b0;
            step_en = 1'b0;
            fix_en  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (fix_en) begin
                q_q <= q_fix;
                r_q <= r_fix;
            end
        end
    end

    // NOTE: datapath registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            rem_q     <= '0;
            quo_q     <= mag_a;
            dvs_q     <= mag_b;
            dvd_q     <= bus.a;
            neg_quo_q <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_q <= bus.is_signed & bus.a[WIDTH-1];
            div0_q    <= (bus.b == '0);
        end else if (step_en) begin
            rem_q <= rem_n;
            quo_q <= quo_n;
        end
    end

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_n),
        .quo_o     (quo_n)
    );

    // Divide-by-zero returns all ones and the original dividend, unsigned-style.
    assign q_fix = div0_q ? '1    : (neg_quo_q ? -quo_q : quo_q);
    assign r_fix = div0_q ? dvd_q : (neg_rem_q ? -rem_q : rem_q);

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.done = (state_q == S_DONE);
    assign bus.busy = (state_q == S_ITER) || (state_q == S_FIX);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, flush/back-to-back/reset
// sequences, and random operands checked against an arithmetic reference model.
module tb_div_unit;
    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    div_unit_if #(.WIDTH(W)) bus ();

    div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] eq;
        logic [31:0] er;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain language-level division, truncating toward zero.
    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r);
        longint sa, sb;
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Called at a negedge; issues one request and waits for done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output logic [31:0] q, output logic [31:0] r,
                          output int lat, output int busy_bad);
        bus.en        = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = s;
        lat           = -1;
        busy_bad      = 0;
        for (int k = 1; k <= LAT + 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                bus.en = 1'b0;
                bus.a  = $urandom;
                bus.b  = $urandom;
            end
            if (bus.done) begin
                lat = k;
                break;
            end
            if (!bus.busy) busy_bad++;
        end
        q = bus.q;
        r = bus.r;
    endtask

    vec_t        vecs[$];
    logic [31:0] q, r, eq, er, a, b;
    logic        s;
    int          lat, busy_bad, done_cnt, first_done, second_done;
    logic [31:0] q1, r1, q2, r2;

    initial begin
        n_checks = 0;
        n_errors = 0;
        bus.en        = 1'b0;
        bus.is_signed = 1'b0;
        bus.is_flush  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        rst_n         = 1'b0;

        vecs.push_back('{"u100_7",    32'h64,         32'h7,         1'b0, 32'd14,        32'd2});
        vecs.push_back('{"s-7_2",     32'hFFFF_FFF9,  32'h2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF});
        vecs.push_back('{"s7_-2",     32'h7,          32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h1});
        vecs.push_back('{"s_ovf",     32'h8000_0000,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0});
        vecs.push_back('{"u_wide",    32'h8000_0000,  32'hFFFF_FFFF, 1'b0, 32'h0,         32'h8000_0000});
        vecs.push_back('{"s_div0",    32'h1234_5678,  32'h0,         1'b1, 32'hFFFF_FFFF, 32'h1234_5678});
        vecs.push_back('{"u_div0",    32'h1234_5678,  32'h0,         1'b0, 32'hFFFF_FFFF, 32'h1234_5678});
        vecs.push_back('{"u0_5",      32'h0,          32'h5,         1'b0, 32'h0,         32'h0});
        vecs.push_back('{"umax_1",    32'hFFFF_FFFF,  32'h1,         1'b0, 32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{"s-100_-7",  32'hFFFF_FF9C,  32'hFFFF_FFF9, 1'b1, 32'd14,        32'hFFFF_FFFE});

        repeat (3) @(negedge clk);
        check("reset_q",    bus.q, 32'h0);
        check("reset_r",    bus.r, 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].s, q, r, lat, busy_bad);
            check({vecs[i].name, "_q"},    q, vecs[i].eq);
            check({vecs[i].name, "_r"},    r, vecs[i].er);
            check({vecs[i].name, "_lat"},  32'(lat), 32'(LAT));
            check({vecs[i].name, "_busy"}, 32'(busy_bad), 32'h0);
            @(negedge clk);
            check({vecs[i].name, "_done1"}, 32'(bus.done), 32'h0);
        end

        // Flush in cycle 10: no done, outputs hold, then a clean rerun
        run_op(32'd100, 32'd7, 1'b0, q, r, lat, busy_bad);
        @(negedge clk);
        bus.en = 1'b1; bus.a = 32'd1000; bus.b = 32'd3; bus.is_signed = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) bus.en = 1'b0;
        end
        bus.is_flush = 1'b1;
        bus.en       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.is_flush = 1'b0;
        bus.en       = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'h0);
        check("flush_done", 32'(bus.done), 32'h0);
        done_cnt = 0;
        for (int k = 0; k < LAT + 4; k++) begin
            @(negedge clk);
            if (bus.done) done_cnt++;
        end
        check("flush_nodone", 32'(done_cnt), 32'h0);
        check("flush_hold_q", bus.q, 32'd14);
        check("flush_hold_r", bus.r, 32'd2);
        run_op(32'd1000, 32'd3, 1'b0, q, r, lat, busy_bad);
        check("reissue_q",   q, 32'd333);
        check("reissue_r",   r, 32'd1);
        check("reissue_lat", 32'(lat), 32'(LAT));
        @(negedge clk);

        // Back-to-back: en held through the first completion
        bus.en = 1'b1; bus.a = 32'd50; bus.b = 32'd5; bus.is_signed = 1'b0;
        done_cnt = 0; first_done = -1; second_done = -1;
        q1 = '0; r1 = '0; q2 = '0; r2 = '0;
        for (int k = 1; k <= 2 * LAT + 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                bus.a = 32'd9;
                bus.b = 32'd4;
            end
            if (k == LAT + 1) bus.en = 1'b0;
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) begin first_done = k; q1 = bus.q; r1 = bus.r; end
                if (done_cnt == 2) begin second_done = k; q2 = bus.q; r2 = bus.r; end
            end
        end
        check("b2b_count", 32'(done_cnt),    32'd2);
        check("b2b_t1",    32'(first_done),  32'(LAT));
        check("b2b_t2",    32'(second_done), 32'(2 * LAT));
        check("b2b_q1", q1, 32'd10);
        check("b2b_r1", r1, 32'd0);
        check("b2b_q2", q2, 32'd2);
        check("b2b_r2", r2, 32'd1);

        // Random operands against the reference model
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = $urandom;
            case (n % 4)
                0: b = b & 32'hFF;
                1: b = b >> $urandom_range(0, 31);
                2: a = a >> $urandom_range(0, 31);
                default: ;
            endcase
            if (n % 13 == 5) b = '0;
            s = 1'($urandom_range(0, 1));
            model(a, b, s, eq, er);
            run_op(a, b, s, q, r, lat, busy_bad);
            check($sformatf("rand%0d_q %h/%h s=%0d", n, a, b, s), q, eq);
            check($sformatf("rand%0d_r %h/%h s=%0d", n, a, b, s), r, er);
            if (lat != LAT) check($sformatf("rand%0d_lat", n), 32'(lat), 32'(LAT));
        end

        // Asynchronous reset mid-operation clears results immediately
        @(negedge clk);
        bus.en = 1'b1; bus.a = 32'd77; bus.b = 32'd5; bus.is_signed = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) bus.en = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_q",    bus.q, 32'h0);
        check("rst_mid_r",    bus.r, 32'h0);
        check("rst_mid_done", 32'(bus.done), 32'h0);
        check("rst_mid_busy", 32'(bus.busy), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(32'd77, 32'd5, 1'b0, q, r, lat, busy_bad);
        check("post_rst_q", q, 32'd15);
        check("post_rst_r", r, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
